fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares one 16-bit match-record FIFO (write side) among NUM_REQ seed-match engines.
//  Round-robin grant with bounded bursts; gates writes on FIFO full so no record is lost.
//  Sits between the mapping engines and the FIFO: drives wr_en/buf_in, observes buf_full.
// PARAMETERS
//  NUM_REQ    4   number of requesting engines (>=2)
//  DATA_W     16  record width; equals FIFO data width
//  MAX_BURST  4   max words accepted per grant before rotation (>=1)
//  ID_W       2   $clog2(NUM_REQ), width of grant_id
// PORTS
//  clk          in   1               system clock
//  rst          in   1               async reset, active-high
//  req_valid    in   NUM_REQ         engine i has a record on req_data slice i
//  req_data     in   NUM_REQ*DATA_W  slice i = req_data[i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ         record of engine i accepted this cycle (valid&ready)
//  fifo_wr_en   out  1               to FIFO wr_en
//  fifo_buf_in  out  DATA_W          to FIFO buf_in
//  fifo_full    in   1               from FIFO buf_full
//  grant_id     out  ID_W            currently granted engine
//  busy         out  1               1 while in GRANT
// BEHAVIOUR
//  Reset: state=IDLE, grant_id=0, last_grant=NUM_REQ-1, burst_cnt=0, busy=0;
//   all outputs 0 (req_ready, fifo_wr_en, fifo_buf_in follow from IDLE). Reset mid-burst
//   aborts; a word presented in the reset cycle is not written.
//  FSM states: IDLE, GRANT (registered). grant_id, burst_cnt, last_grant registered.
//  Write path combinational, zero latency:
//   accept = (state==GRANT) & req_valid[grant_id] & !fifo_full
//   fifo_wr_en = accept; fifo_buf_in = slice grant_id when GRANT, else 0
//   req_ready[i] = accept & (i==grant_id)
//  Pick: rr search starting at (last_grant+1) mod NUM_REQ, wrapping; returns first
//   set req_valid bit, last_grant itself checked last.
//  IDLE: if any req_valid -> GRANT, grant_id=pick, burst_cnt=0. Else stay.
//  GRANT, end conditions (evaluated each cycle):
//   a) accept & burst_cnt==MAX_BURST-1   (burst exhausted)
//   b) !req_valid[grant_id]              (requester released)
//   on end: last_grant<=grant_id; if any req_valid (pick computed with
//   last_grant=grant_id) -> stay GRANT, new grant_id, burst_cnt=0; else -> IDLE.
//   Re-grant to same engine allowed only if no other engine is valid.
//  GRANT, no end: accept -> burst_cnt+1; fifo_full -> stall, burst_cnt and grant held
//   (full never causes rotation).
//  burst_cnt width $clog2(MAX_BURST)+1, never exceeds MAX_BURST-1.
//  Requests asserted in the same cycle as a rotation join the next pick.
//  Engines must hold req_data stable while req_valid & !req_ready.
//  At most one fifo_wr_en per cycle; never asserted while fifo_full=1.
// STRUCTURE
//  Package dna_fifo_pkg: DATA_W, NUM_REQ, MAX_BURST defaults; state enum {IDLE,GRANT}.
//  Sub-module rr_pick (combinational): inputs req_valid, last_grant; outputs any, idx.
//  Top: FSM + counters + write mux, instantiates rr_pick once.
// TESTING
//  1 Reset, req_valid=4'b0001, data0=16'hA001.. 6 words, full=0 -> words 1-4 written
//    on consecutive cycles, grant held on 0 (only requester), all 6 written in order.
//  2 req_valid=4'b1111 continuously, full=0 -> grant order 0,1,2,3,0 each exactly
//    4 writes; fifo write count equals sum of req_ready pulses.
//  3 Engine 2 granted, fifo_full=1 for 5 cycles after 2nd word -> no wr_en, grant_id
//    stays 2, burst_cnt stays 2; after release exactly 2 more words then rotate.
//  4 Engine 1 drops valid after 1 word while engine 3 valid -> grant_id=3 next cycle,
//    last_grant=1; engine 2 asserting later is served before engine 1.
//  5 Assert rst mid-burst (engine 0, burst_cnt=2) -> outputs 0 immediately, IDLE;
//    after release with 4'b1111 first grant is engine 0.
//  Scoreboard: FIFO-side model never receives a write while full; no record lost/duped.

Source files
------------

// File: rtl/dna_fifo_pkg.sv
// dna_fifo_pkg: shared defaults and FSM state type for the match-record FIFO write arbiter
package dna_fifo_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MAX_BURST = 4;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search from last_grant+1, wrapping, with last_grant itself checked last
module rr_pick
  import dna_fifo_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  // Walk the candidates farthest-first so the nearest valid one wins.
  always_comb begin
    logic [ID_W-1:0] c;
    c = '0;
    any = |req_valid;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = ID_W'((int'(last_grant) + k) % NUM_REQ);
      idx = req_valid[c] ? c : idx;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ engines
module fifo_wr_arbiter
  import dna_fifo_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_buf_in,
  input  logic                      fifo_full,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  arb_state_t state, state_nxt;
  logic [ID_W-1:0] last_grant, last_nxt, grant_nxt, pick_last, pick_idx;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic pick_any, in_grant, accept, burst_end, rearb;
  assign in_grant = state == GRANT;
  assign accept = in_grant && req_valid[grant_id] && !fifo_full;
  assign burst_end = in_grant && (!req_valid[grant_id] || (accept && burst_cnt == CNT_W'(MAX_BURST - 1)));
  assign rearb = !in_grant || burst_end;
  // On rotation the search starts after the engine just served, not the stored last_grant.
  assign pick_last = in_grant ? grant_id : last_grant;
  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid(req_valid),
    .last_grant(pick_last),
    .any(pick_any),
    .idx(pick_idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant_id <= grant_nxt;
      last_grant <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end
  // A full FIFO only stalls: no end condition depends on fifo_full.
  always_comb begin
    state_nxt = rearb ? (pick_any ? GRANT : IDLE) : state;
    grant_nxt = (rearb && pick_any) ? pick_idx : grant_id;
    last_nxt = burst_end ? grant_id : last_grant;
    cnt_nxt = rearb ? '0 : accept ? burst_cnt + 1'b1 : burst_cnt;
  end
  always_comb begin
    busy = in_grant;
    fifo_wr_en = accept;
    fifo_buf_in = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_buf_in = (in_grant && grant_id == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : fifo_buf_in;
      req_ready[i] = accept && grant_id == ID_W'(i);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench with simple engine models and a FIFO-side write monitor
module tb_fifo_wr_arbiter;
  logic clk = 0, rst = 1, fifo_full = 0, full_set = 0;
  logic [3:0] req_valid = '0, req_ready, rdy;
  logic [63:0] req_data = '0;
  logic fifo_wr_en, busy;
  logic [15:0] fifo_buf_in;
  logic [1:0] grant_id;
  int checks = 0, errors = 0, wr_cnt = 0, rdy_cnt = 0;
  int left[4], n[4];
  logic [15:0] dat[4];

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_buf_in(fifo_buf_in), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    fifo_full = full_set;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = left[i] > 0;
      req_data[i*16 +: 16] = dat[i];
    end
  endtask

  // Engines pop a word the cycle after it was accepted; returns 3 time units after the edge.
  task automatic tick();
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rdy[i]) begin
        left[i]--;
        dat[i]++;
      end
    drive();
    #2;
  endtask

  task automatic do_reset();
    rst = 1;
    full_set = 0;
    for (int i = 0; i < 4; i++) left[i] = 0;
    tick();
  endtask

  always @(negedge clk) begin
    if (fifo_wr_en) wr_cnt++;
    rdy_cnt += $countones(req_ready);
    if (fifo_wr_en || fifo_full) check("wr_while_full", fifo_wr_en & fifo_full, 0);
    check("ready_vs_wr", $countones(req_ready), fifo_wr_en);
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      dat[i] = '0;
      n[i] = 0;
    end
    drive();
    tick();
    check("rst_busy", busy, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_buf", fifo_buf_in, 0);
    check("rst_last", dut.last_grant, 3);
    // Test 1: single requester, six words straddling a burst boundary
    left[0] = 6;
    dat[0] = 16'hA001;
    drive();
    #1;
    check("t1_rst_cycle_wr", fifo_wr_en, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_wr_en", fifo_wr_en, 1);
      check("t1_data", fifo_buf_in, 16'hA001 + 16'(i));
      check("t1_grant", grant_id, 0);
    end
    tick();
    check("t1_drop_wr", fifo_wr_en, 0);
    check("t1_drop_busy", busy, 1);
    tick();
    check("t1_idle", busy, 0);
    // Test 2: all four engines, strict rotation in bursts of four
    do_reset();
    for (int i = 0; i < 4; i++) begin
      left[i] = 20;
      dat[i] = 16'hB000 + 16'(i * 256);
    end
    rst = 0;
    tick();
    check("t2_idle", busy, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t2_grant", grant_id, (c / 4) % 4);
      check("t2_wr_en", fifo_wr_en, 1);
      check("t2_data", fifo_buf_in, 16'hB000 + 16'(((c / 4) % 4) * 256 + n[(c / 4) % 4]));
      n[(c / 4) % 4]++;
    end
    for (int i = 0; i < 4; i++) left[i] = 0;
    tick();
    check("t2_stop_wr", fifo_wr_en, 0);
    check("t2_stop_grant", grant_id, 1);
    tick();
    check("t2_stop_idle", busy, 0);
    // Test 3: full stalls engine 2 mid-burst without rotating
    do_reset();
    left[2] = 10;
    dat[2] = 16'hC000;
    rst = 0;
    tick();
    tick();
    check("t3_grant", grant_id, 2);
    check("t3_w0", fifo_buf_in, 16'hC000);
    left[3] = 10;
    dat[3] = 16'hD000;
    tick();
    check("t3_w1", fifo_buf_in, 16'hC001);
    check("t3_w1_en", fifo_wr_en, 1);
    full_set = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_wr", fifo_wr_en, 0);
      check("t3_stall_grant", grant_id, 2);
      check("t3_stall_cnt", dut.burst_cnt, 2);
    end
    full_set = 0;
    tick();
    check("t3_w2", fifo_buf_in, 16'hC002);
    check("t3_w2_en", fifo_wr_en, 1);
    tick();
    check("t3_w3", fifo_buf_in, 16'hC003);
    check("t3_w3_grant", grant_id, 2);
    tick();
    check("t3_rot_grant", grant_id, 3);
    check("t3_rot_data", fifo_buf_in, 16'hD000);
    for (int i = 0; i < 4; i++) left[i] = 0;
    tick();
    check("t3_stop_wr", fifo_wr_en, 0);
    // Test 4: engine 1 releases early; later requesters take their turn in ring order
    do_reset();
    left[1] = 1;
    dat[1] = 16'hE100;
    left[3] = 4;
    dat[3] = 16'hD300;
    rst = 0;
    tick();
    tick();
    check("t4_g1", grant_id, 1);
    check("t4_g1_data", fifo_buf_in, 16'hE100);
    tick();
    check("t4_drop_wr", fifo_wr_en, 0);
    check("t4_drop_grant", grant_id, 1);
    left[2] = 3;
    dat[2] = 16'hF200;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_g3", grant_id, 3);
      check("t4_g3_data", fifo_buf_in, 16'hD300 + 16'(i));
      if (i == 0) check("t4_last", dut.last_grant, 1);
    end
    tick();
    check("t4_g2", grant_id, 2);
    check("t4_g2_data", fifo_buf_in, 16'hF200);
    left[1] = 2;
    tick();
    check("t4_g2_w1", fifo_buf_in, 16'hF201);
    tick();
    check("t4_g2_w2", fifo_buf_in, 16'hF202);
    tick();
    check("t4_g2_drop", fifo_wr_en, 0);
    tick();
    check("t4_g1_again", grant_id, 1);
    check("t4_g1_again_data", fifo_buf_in, 16'hE101);
    tick();
    check("t4_g1_w2", fifo_buf_in, 16'hE102);
    tick();
    check("t4_g1_drop", fifo_wr_en, 0);
    tick();
    check("t4_idle", busy, 0);
    // Test 5: asynchronous reset in the middle of a burst
    do_reset();
    left[0] = 10;
    dat[0] = 16'hA100;
    rst = 0;
    tick();
    tick();
    tick();
    tick();
    check("t5_pre_cnt", dut.burst_cnt, 2);
    check("t5_pre_data", fifo_buf_in, 16'hA102);
    rst = 1;
    #1;
    check("t5_rst_wr", fifo_wr_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", req_ready, 0);
    check("t5_rst_buf", fifo_buf_in, 0);
    check("t5_rst_grant", grant_id, 0);
    for (int i = 1; i < 4; i++) begin
      left[i] = 10;
      dat[i] = 16'h5000 + 16'(i * 256);
    end
    rst = 0;
    tick();
    check("t5_first_grant", grant_id, 0);
    check("t5_first_data", fifo_buf_in, 16'hA102);
    check("t5_first_wr", fifo_wr_en, 1);
    for (int i = 0; i < 4; i++) left[i] = 0;
    tick();
    check("t5_stop_wr", fifo_wr_en, 0);
    check("wr_total", wr_cnt, 44);
    check("wr_vs_ready_total", wr_cnt, rdy_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
